ufo_block_acc: RTL

Downstream consumer of the UFO output stream. Accepts 64-bit signed fixed-point samples qualified by a valid strobe and accumulates them in non-overlapping blocks of BLOCK_LEN samples using saturating addition. At the end of each block it emits one result: the block sum, the block mean, and a saturation flag. The input side has no backpressure, so the block never stalls and never drops a valid sample, except when i_clear is asserted.

---
 rtl/ufo_pkg.sv | 41 ++++
 rtl/ufo_sat_add.sv | 28 ++
 rtl/ufo_block_acc.sv | 108 ++++++++++
 3 files changed

// File: rtl/ufo_pkg.sv
// rtl/ufo_pkg.sv - shared types, saturation limits and saturating add for the UFO block accumulator
package ufo_pkg;

  localparam int UFO_DW = 64;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Limits are built for any width up to UFO_DW; callers keep the low bits they need.
  function automatic logic [UFO_DW-1:0] sat_max_f(input int w);
    logic [UFO_DW-1:0] r;
    r = '0;
    for (int i = 0; i < UFO_DW; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [UFO_DW-1:0] sat_min_f(input int w);
    logic [UFO_DW-1:0] r;
    r = '0;
    for (int i = 0; i < UFO_DW; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  localparam logic [UFO_DW-1:0] SAT_MAX = sat_max_f(UFO_DW);
  localparam logic [UFO_DW-1:0] SAT_MIN = sat_min_f(UFO_DW);

  function automatic logic [UFO_DW-1:0] sat_add(input logic [UFO_DW-1:0] a,
                                                input logic [UFO_DW-1:0] b,
                                                output logic overflow);
    logic [UFO_DW:0] full;
    full     = {a[UFO_DW-1], a} + {b[UFO_DW-1], b};
    overflow = full[UFO_DW] ^ full[UFO_DW-1];
    if (!overflow) return full[UFO_DW-1:0];
    else if (full[UFO_DW]) return SAT_MIN;
    else return SAT_MAX;
  endfunction

endpackage

// File: rtl/ufo_sat_add.sv
// rtl/ufo_sat_add.sv - combinational signed saturating adder with clamp indication
module ufo_sat_add
  import ufo_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  clamp
);

  localparam logic [UFO_DW-1:0]     MAX_FULL = sat_max_f(DATA_WIDTH);
  localparam logic [UFO_DW-1:0]     MIN_FULL = sat_min_f(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_V    = MAX_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MIN_V    = MIN_FULL[DATA_WIDTH-1:0];

  logic [DATA_WIDTH:0] full;

  // The two top bits of the widened sum disagree exactly when the result left the range.
  always_comb begin
    full  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    clamp = full[DATA_WIDTH] ^ full[DATA_WIDTH-1];
    sum   = full[DATA_WIDTH-1:0];
    if (clamp) sum = full[DATA_WIDTH] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/ufo_block_acc.sv
// rtl/ufo_block_acc.sv - block-wise saturating accumulator emitting sum, mean and saturation flag
module ufo_block_acc
  import ufo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BLOCK_LEN  = 16,
  parameter int CNT_WIDTH  = $clog2(BLOCK_LEN)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic [DATA_WIDTH-1:0] o_mean,
  output logic                  o_sat,
  output logic                  o_valid,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BLOCK_LEN - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    sat_seen_q, sat_seen_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    sat_q, sat_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   add_sum;
  logic                    add_clamp;

  ufo_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
    .a     (acc_q),
    .b     (i_data),
    .sum   (add_sum),
    .clamp (add_clamp)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sat_seen_d = sat_seen_q;
    sum_d      = sum_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;
    if (i_clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      acc_d      = '0;
      sat_seen_d = 1'b0;
    end else if (i_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d    = ACCUM;
          cnt_d      = cnt_q + 1'b1;
          acc_d      = add_sum;
          sat_seen_d = sat_seen_q | add_clamp;
        end
        ACCUM: begin
          if (cnt_q == CNT_LAST) begin
            // Final sample of the block: publish and restart without a bubble.
            state_d    = IDLE;
            cnt_d      = '0;
            acc_d      = '0;
            sat_seen_d = 1'b0;
            sum_d      = add_sum;
            sat_d      = sat_seen_q | add_clamp;
            valid_d    = 1'b1;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            acc_d      = add_sum;
            sat_seen_d = sat_seen_q | add_clamp;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sat_seen_q <= 1'b0;
      sum_q      <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sat_seen_q <= sat_seen_d;
      sum_q      <= sum_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_mean  = $signed(sum_q) >>> CNT_WIDTH;
  assign o_sat   = sat_q;
  assign o_valid = valid_q;
  assign o_count = cnt_q;

endmodule
